bsx_stream_tx: RTL and testbench

// Satellaview broadcast stream transmitter: reads a channel's packet data

---
 rtl/bsx_stream_tx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bsx_stream_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsx_stream_tx.sv
// Satellaview BS-X stream transmitter: fetches a channel's packet data from cart
// memory into two 22-byte fragment buffers and serves them to the base register unit.
module bsx_stream_tx #(
  parameter int FRAG_BYTES = 22,
  parameter int LEN_W      = 16,
  parameter int PAGE_W     = 10
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              start,
  input  logic [PAGE_W-1:0] page_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              busy,
  output logic              mem_req,
  output logic [23:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              frag_valid,
  output logic [7:0]        frag_status,
  output logic [7:0]        data_out,
  input  logic              data_rd,
  input  logic              status_rd,
  output logic [6:0]        queue_cnt
);

  localparam int IDX_W = $clog2(FRAG_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAG_BYTES - 1);
  localparam logic [IDX_W:0]   FRAG_OFS = (IDX_W+1)'(FRAG_BYTES);
  localparam logic [LEN_W-1:0] FRAG_LEN = LEN_W'(FRAG_BYTES);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [23:0]       base_q, base_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  tmp_q, tmp_d;
  logic [LEN_W-1:0]  total_q, total_d;
  logic [LEN_W-1:0]  fidx_q, fidx_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              wr_buf_q, wr_buf_d;
  logic              rd_buf_q, rd_buf_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        first_q, first_d;
  logic [1:0]        last_q, last_d;
  logic [PAGE_W-1:0] pend_page_q, pend_page_d;
  logic [LEN_W-1:0]  pend_len_q, pend_len_d;

  logic [7:0]        buf_q [0:2*FRAG_BYTES-1];
  logic              wr_en_s;
  logic [7:0]        wr_data_s;
  logic [IDX_W:0]    wr_addr_s;
  logic [IDX_W:0]    rd_addr_s;
  logic              ld_s;
  logic              flush_s;
  logic [PAGE_W-1:0] ld_page_s;
  logic [LEN_W-1:0]  ld_len_s;
  logic              other_buf_s;
  logic              unused_status_rd_s;

  // status_rd only reports; it never alters state
  assign unused_status_rd_s = status_rd;

  assign other_buf_s = ~wr_buf_q;
  assign wr_addr_s   = {1'b0, byte_idx_q} + (wr_buf_q ? FRAG_OFS : {(IDX_W+1){1'b0}});
  assign rd_addr_s   = {1'b0, rd_ptr_q} + (rd_buf_q ? FRAG_OFS : {(IDX_W+1){1'b0}});

  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = ((state_q == ST_FETCH) && ({{(LEN_W-IDX_W){1'b0}}, byte_idx_q} < rem_q))
                       || (state_q == ST_ABORT);
  assign mem_addr    = base_q + {{(24-LEN_W){1'b0}}, off_q};
  assign frag_valid  = full_q[rd_buf_q];
  assign frag_status = frag_valid ? {last_q[rd_buf_q], 2'b00, first_q[rd_buf_q], 4'b0000} : 8'h00;
  assign data_out    = frag_valid ? buf_q[rd_addr_s] : 8'h00;
  assign queue_cnt   = (remain_q > LEN_W'(127)) ? 7'd127 : remain_q[6:0];

  // Next-state logic: consumer retire, fetch engine, then start/abort overrides
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    off_d       = off_q;
    rem_d       = rem_q;
    tmp_d       = tmp_q;
    total_d     = total_q;
    fidx_d      = fidx_q;
    remain_d    = remain_q;
    byte_idx_d  = byte_idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_buf_d    = wr_buf_q;
    rd_buf_d    = rd_buf_q;
    full_d      = full_q;
    first_d     = first_q;
    last_d      = last_q;
    pend_page_d = pend_page_q;
    pend_len_d  = pend_len_q;
    wr_en_s     = 1'b0;
    wr_data_s   = 8'h00;
    ld_s        = 1'b0;
    flush_s     = 1'b0;
    ld_page_s   = page_in;
    ld_len_s    = len_in;

    if (data_rd && frag_valid) begin
      if (rd_ptr_q == LAST_IDX) begin
        full_d[rd_buf_q] = 1'b0;
        rd_buf_d         = ~rd_buf_q;
        rd_ptr_d         = {IDX_W{1'b0}};
        remain_d         = remain_q - LEN_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + IDX_W'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_COUNT: begin
        total_d = total_q + LEN_W'(1);
        if (tmp_q <= FRAG_LEN) begin
          remain_d = total_q + LEN_W'(1);
          state_d  = ST_FETCH;
        end else begin
          tmp_d = tmp_q - FRAG_LEN;
        end
      end
      ST_FETCH: begin
        if (mem_req) begin
          if (mem_ack) begin
            wr_en_s   = 1'b1;
            wr_data_s = mem_data;
            off_d     = off_q + LEN_W'(1);
          end else begin
            wr_en_s = 1'b0;
          end
        end else begin
          // beyond the stream length: pad with zeros, no memory access
          wr_en_s   = 1'b1;
          wr_data_s = 8'h00;
        end
        if (wr_en_s) begin
          if (byte_idx_q == LAST_IDX) begin
            full_d[wr_buf_q]  = 1'b1;
            first_d[wr_buf_q] = (fidx_q == {LEN_W{1'b0}});
            last_d[wr_buf_q]  = (rem_q <= FRAG_LEN);
            wr_buf_d          = other_buf_s;
            fidx_d            = fidx_q + LEN_W'(1);
            byte_idx_d        = {IDX_W{1'b0}};
            rem_d             = (rem_q > FRAG_LEN) ? (rem_q - FRAG_LEN) : {LEN_W{1'b0}};
            if ((fidx_d < total_q) && !full_d[other_buf_s]) begin
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q;
        end
      end
      ST_WAIT: begin
        if (remain_q == {LEN_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else if ((fidx_q < total_q) && !full_q[wr_buf_q]) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ABORT: begin
        if (mem_ack) begin
          ld_s      = 1'b1;
          ld_page_s = pend_page_q;
          ld_len_s  = pend_len_q;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A restart with a request in flight parks in ABORT until the ack retires it
    if (start) begin
      if (mem_req && !mem_ack) begin
        state_d     = ST_ABORT;
        pend_page_d = page_in;
        pend_len_d  = len_in;
        flush_s     = 1'b1;
      end else begin
        ld_s      = 1'b1;
        ld_page_s = page_in;
        ld_len_s  = len_in;
      end
    end else begin
      pend_page_d = pend_page_q;
    end

    if (ld_s || flush_s) begin
      full_d     = 2'b00;
      rd_ptr_d   = {IDX_W{1'b0}};
      rd_buf_d   = 1'b0;
      wr_buf_d   = 1'b0;
      remain_d   = {LEN_W{1'b0}};
      byte_idx_d = {IDX_W{1'b0}};
    end else begin
      full_d = full_d;
    end

    if (ld_s) begin
      state_d = ST_COUNT;
      base_d  = {ld_page_s, 14'h0000};
      rem_d   = ld_len_s;
      tmp_d   = ld_len_s;
      off_d   = {LEN_W{1'b0}};
      total_d = {LEN_W{1'b0}};
      fidx_d  = {LEN_W{1'b0}};
    end else begin
      base_d = base_d;
    end
  end

  // State registers
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= 24'h000000;
      off_q       <= {LEN_W{1'b0}};
      rem_q       <= {LEN_W{1'b0}};
      tmp_q       <= {LEN_W{1'b0}};
      total_q     <= {LEN_W{1'b0}};
      fidx_q      <= {LEN_W{1'b0}};
      remain_q    <= {LEN_W{1'b0}};
      byte_idx_q  <= {IDX_W{1'b0}};
      rd_ptr_q    <= {IDX_W{1'b0}};
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      full_q      <= 2'b00;
      first_q     <= 2'b00;
      last_q      <= 2'b00;
      pend_page_q <= {PAGE_W{1'b0}};
      pend_len_q  <= {LEN_W{1'b0}};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      off_q       <= off_d;
      rem_q       <= rem_d;
      tmp_q       <= tmp_d;
      total_q     <= total_d;
      fidx_q      <= fidx_d;
      remain_q    <= remain_d;
      byte_idx_q  <= byte_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      full_q      <= full_d;
      first_q     <= first_d;
      last_q      <= last_d;
      pend_page_q <= pend_page_d;
      pend_len_q  <= pend_len_d;
    end
  end

  // Fragment buffer storage; contents are only visible through full flags
  always_ff @(posedge clkin) begin
    if (wr_en_s) begin
      buf_q[wr_addr_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_bsx_stream_tx.sv
// Bench for bsx_stream_tx: memory responder with configurable latency, fragment
// scoreboard filled at stream start, table of streams plus abort/reset sequences.
module tb_bsx_stream_tx;

  logic        clkin = 1'b0;
  logic        reset, start, mem_ack, data_rd, status_rd;
  logic [9:0]  page_in;
  logic [15:0] len_in;
  logic [7:0]  mem_data;
  logic        busy, mem_req, frag_valid;
  logic [23:0] mem_addr;
  logic [7:0]  frag_status, data_out;
  logic [6:0]  queue_cnt;

  bsx_stream_tx dut (
    .clkin(clkin), .reset(reset), .start(start), .page_in(page_in), .len_in(len_in),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .frag_valid(frag_valid), .frag_status(frag_status),
    .data_out(data_out), .data_rd(data_rd), .status_rd(status_rd), .queue_cnt(queue_cnt)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [7:0]   status;
    logic [6:0]   qcnt;
    logic [175:0] data;
  } exp_frag_t;

  typedef struct {
    logic [9:0]  page;
    logic [15:0] len;
    int          dly;
    int          nfrag;
    logic [7:0]  st0;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          n_ack = 0;
  logic [23:0] addr_q[$];
  exp_frag_t   frag_q[$];
  vec_t        vecs[6];

  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [9:0] page, input int len, input int nf, input logic [7:0] st0);
    exp_frag_t   e;
    logic [23:0] base;
    int          idx;
    base = {page, 14'h0000};
    for (int k = 0; k < nf; k++) begin
      e.status = (k == 0) ? st0 : ((k == nf - 1) ? 8'h80 : 8'h00);
      e.qcnt   = (nf - k > 127) ? 7'd127 : 7'(nf - k);
      for (int j = 0; j < 22; j++) begin
        idx = k * 22 + j;
        e.data[j*8 +: 8] = (idx < len) ? mem_f(base + 24'(idx)) : 8'h00;
      end
      frag_q.push_back(e);
    end
    for (int i = 0; i < len; i++) addr_q.push_back(base + 24'(i));
  endtask

  task automatic do_start(input logic [9:0] page, input logic [15:0] len);
    page_in = page;
    len_in  = len;
    start   = 1'b1;
    @(posedge clkin); #1;
    start   = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (frag_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clkin); #1;
    end
    chk("frag_valid_timeout", 32'(frag_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(posedge clkin); #1;
    end
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic read_frag();
    exp_frag_t e;
    bit        ok;
    wait_valid(ok);
    if (!ok) return;
    if (frag_q.size() == 0) begin
      chk("frag_extra", 32'(frag_valid), 32'd0);
      return;
    end
    e = frag_q.pop_front();
    chk("frag_status", 32'(frag_status), 32'(e.status));
    chk("queue_cnt", 32'(queue_cnt), 32'(e.qcnt));
    for (int j = 0; j < 22; j++) begin
      chk("data_out", 32'(data_out), 32'(e.data[j*8 +: 8]));
      data_rd   = 1'b1;
      status_rd = (j == 0);
      @(posedge clkin); #1;
      data_rd   = 1'b0;
      status_rd = 1'b0;
    end
  endtask

  // Memory model: acks each request after ack_delay idle cycles, checks the address
  initial begin : responder
    int wcnt;
    wcnt     = 0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(posedge clkin); #1;
      mem_ack = 1'b0;
      if (reset) begin
        wcnt = 0;
      end else if (mem_req) begin
        if (wcnt >= ack_delay) begin
          wcnt     = 0;
          mem_ack  = 1'b1;
          mem_data = mem_f(mem_addr);
          n_ack++;
          if (addr_q.size() == 0) chk("mem_addr_extra", 32'(mem_addr), 32'hFFFF_FFFF);
          else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : main
    logic [23:0] pend;
    reset = 1'b1; start = 1'b0; data_rd = 1'b0; status_rd = 1'b0;
    page_in = 10'd0; len_in = 16'd0;
    vecs[0] = '{10'h003, 16'd44,    0, 2,   8'h10};
    vecs[1] = '{10'h000, 16'd0,     0, 1,   8'h90};
    vecs[2] = '{10'h005, 16'd23,    0, 2,   8'h10};
    vecs[3] = '{10'h155, 16'd50,    5, 3,   8'h10};
    vecs[4] = '{10'h3FF, 16'd16390, 0, 745, 8'h10};
    vecs[5] = '{10'h007, 16'd4400,  0, 200, 8'h10};

    repeat (3) @(posedge clkin); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_frag_valid", 32'(frag_valid), 32'd0);
    chk("rst_frag_status", 32'(frag_status), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_queue_cnt", 32'(queue_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clkin); #1;

    for (int v = 0; v < 6; v++) begin
      ack_delay = vecs[v].dly;
      n_ack = 0;
      push_stream(vecs[v].page, int'(vecs[v].len), vecs[v].nfrag, vecs[v].st0);
      do_start(vecs[v].page, vecs[v].len);
      chk("busy_start", 32'(busy), 32'd1);
      chk("valid_count", 32'(frag_valid), 32'd0);
      // a read with nothing valid must not advance the pointer
      data_rd = 1'b1;
      @(posedge clkin); #1;
      data_rd = 1'b0;
      for (int k = 0; k < vecs[v].nfrag; k++) begin
        read_frag();
        if (k < vecs[v].nfrag - 1 && vecs[v].dly > 0) chk("gap_valid", 32'(frag_valid), 32'd0);
      end
      wait_idle();
      chk("n_ack", 32'(n_ack), 32'(vecs[v].len));
      chk("addr_left", 32'(addr_q.size()), 32'd0);
      chk("frag_left", 32'(frag_q.size()), 32'd0);
      chk("queue_cnt_end", 32'(queue_cnt), 32'd0);
    end

    // restart while a slow read is outstanding
    ack_delay = 5;
    n_ack = 0;
    push_stream(10'h002, 100, 5, 8'h10);
    do_start(10'h002, 16'd100);
    for (int i = 0; i < 500; i++) begin
      if (n_ack >= 3) break;
      @(posedge clkin); #1;
    end
    chk("abort_acks", 32'(n_ack), 32'd3);
    repeat (2) @(posedge clkin); #1;
    chk("abort_req", 32'(mem_req), 32'd1);
    frag_q.delete();
    pend = addr_q.pop_front();
    addr_q.delete();
    addr_q.push_back(pend);
    push_stream(10'h009, 30, 2, 8'h10);
    do_start(10'h009, 16'd30);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_valid", 32'(frag_valid), 32'd0);
    chk("abort_qcnt", 32'(queue_cnt), 32'd0);
    read_frag();
    read_frag();
    wait_idle();
    chk("abort_addr_left", 32'(addr_q.size()), 32'd0);

    // reset in the middle of a stream, then a clean stream afterwards
    ack_delay = 0;
    push_stream(10'h001, 60, 3, 8'h10);
    do_start(10'h001, 16'd60);
    repeat (10) @(posedge clkin); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_valid", 32'(frag_valid), 32'd0);
    chk("mid_rst_status", 32'(frag_status), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_qcnt", 32'(queue_cnt), 32'd0);
    @(posedge clkin); #1;
    reset = 1'b0;
    addr_q.delete();
    frag_q.delete();
    @(posedge clkin); #1;
    push_stream(10'h004, 22, 1, 8'h90);
    do_start(10'h004, 16'd22);
    read_frag();
    wait_idle();
    chk("post_rst_addr_left", 32'(addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
